// File: rtl/vram_arbiter.sv
// Text VRAM arbiter: VGA scanout reads, CPU reads and posted CPU writes share one RAM port.
// Define VRAM_ARB_STATS_EN to add VGA-grant and forced-write statistics counters.
module vram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ovf,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_vid_cnt,
  output logic [15:0]       stat_force_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM  = SW'(STARVE_LIM);
  localparam logic [SW-1:0] SONE = SW'(1);
  localparam logic [PW:0]   PONE = (PW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VID  = 2'd1;
  localparam logic [1:0] S_CRD  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [SW-1:0]     starve_cnt;
  logic              rd_pending;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT-1:0] vid_pipe;
  logic [RD_LAT-1:0] cpu_pipe;
  logic              empty;
  logic              full;
  logic              forced;
  logic              enq;
  logic [1:0]        slot;

  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) &&
                    (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign forced   = !empty && (starve_cnt == LIM);
  assign enq      = cpu_we && !full;
  assign cpu_busy = full || rd_pending;

  // Reads wait for an empty FIFO so they always see earlier posted writes
  always_comb begin
    slot = S_IDLE;
    priority case (1'b1)
      forced:              slot = S_WR;
      vid_req:             slot = S_VID;
      rd_pending && empty: slot = S_CRD;
      !empty:              slot = S_WR;
      default:             slot = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wr_ptr[PW-1:0]] <= cpu_addr;
      fifo_data[wr_ptr[PW-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      rd_pending <= 1'b0;
      rd_addr    <= '0;
      vid_pipe   <= '0;
      cpu_pipe   <= '0;
      vid_gnt    <= 1'b0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
      cpu_ovf    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      vid_gnt <= slot == S_VID;
      mem_we  <= slot == S_WR;
      unique case (slot)
        S_VID: mem_addr <= vid_addr;
        S_CRD: mem_addr <= rd_addr;
        S_WR: begin
          mem_addr  <= fifo_addr[rd_ptr[PW-1:0]];
          mem_wdata <= fifo_data[rd_ptr[PW-1:0]];
        end
        default: ;
      endcase

      if (slot == S_WR) rd_ptr <= rd_ptr + PONE;
      if (enq) wr_ptr <= wr_ptr + PONE;
      cpu_ovf <= cpu_we && full;

      if (slot == S_WR || empty) starve_cnt <= '0;
      else if (starve_cnt != LIM) starve_cnt <= starve_cnt + SONE;

      if (slot == S_CRD) begin
        rd_pending <= 1'b0;
      end else if (cpu_re && !rd_pending) begin
        rd_pending <= 1'b1;
        rd_addr    <= cpu_addr;
      end

      for (int i = RD_LAT - 1; i > 0; i--) begin
        vid_pipe[i] <= vid_pipe[i-1];
        cpu_pipe[i] <= cpu_pipe[i-1];
      end
      vid_pipe[0] <= slot == S_VID;
      cpu_pipe[0] <= slot == S_CRD;

      vid_valid  <= vid_pipe[RD_LAT-1];
      cpu_rvalid <= cpu_pipe[RD_LAT-1];
      if (vid_pipe[RD_LAT-1]) vid_data  <= mem_q;
      if (cpu_pipe[RD_LAT-1]) cpu_rdata <= mem_q;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_vid_cnt   <= '0;
      stat_force_cnt <= '0;
    end else begin
      if (slot == S_VID) stat_vid_cnt <= stat_vid_cnt + 16'd1;
      if (forced) stat_force_cnt <= stat_force_cnt + 16'd1;
    end
  end
`endif

endmodule
